// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Control FSM sequencing a shared multicycle RISC-V datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] c_FETCH    = 4'd0;
  localparam logic [3:0] c_DECODE   = 4'd1;
  localparam logic [3:0] c_MEMADR   = 4'd2;
  localparam logic [3:0] c_MEMREAD  = 4'd3;
  localparam logic [3:0] c_MEMWB    = 4'd4;
  localparam logic [3:0] c_MEMWRITE = 4'd5;
  localparam logic [3:0] c_EXECR    = 4'd6;
  localparam logic [3:0] c_EXECI    = 4'd7;
  localparam logic [3:0] c_ALUWB    = 4'd8;
  localparam logic [3:0] c_BRANCH   = 4'd9;
  localparam logic [3:0] c_JAL      = 4'd10;
  localparam logic [3:0] c_LUI      = 4'd11;
  localparam logic [3:0] c_TRAP     = 4'd12;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic       w_f3_alu_ok;
  logic       w_f3_br_ok;
  logic       w_f3_mem_ok;
  logic [2:0] w_alu_op;

  assign w_f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3[2:1] == 2'b11);
  assign w_f3_br_ok  = (funct3[2:1] == 2'b00);
  assign w_f3_mem_ok = (funct3 == 3'b010);
  assign state       = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = c_FETCH;
    case (r_state)
      c_FETCH:    w_next_state = mem_ready ? c_DECODE : c_FETCH;
      c_DECODE: begin
        case (op)
          c_OP_LOAD,
          c_OP_STORE:  w_next_state = w_f3_mem_ok ? c_MEMADR : c_TRAP;
          c_OP_RTYPE:  w_next_state = w_f3_alu_ok ? c_EXECR  : c_TRAP;
          c_OP_ITYPE:  w_next_state = w_f3_alu_ok ? c_EXECI  : c_TRAP;
          c_OP_BRANCH: w_next_state = w_f3_br_ok  ? c_BRANCH : c_TRAP;
          c_OP_JAL:    w_next_state = c_JAL;
          c_OP_LUI:    w_next_state = c_LUI;
          default:     w_next_state = c_TRAP;
        endcase
      end
      c_MEMADR:   w_next_state = (op == c_OP_STORE) ? c_MEMWRITE : c_MEMREAD;
      c_MEMREAD:  w_next_state = mem_ready ? c_MEMWB : c_MEMREAD;
      c_MEMWB:    w_next_state = c_FETCH;
      c_MEMWRITE: w_next_state = mem_ready ? c_FETCH : c_MEMWRITE;
      c_EXECR,
      c_EXECI,
      c_LUI,
      c_JAL:      w_next_state = c_ALUWB;
      c_ALUWB,
      c_BRANCH:   w_next_state = c_FETCH;
      c_TRAP:     w_next_state = c_TRAP;
      default:    w_next_state = c_FETCH;
    endcase
  end

  // Shared ALU decode; the sub variant is only honoured in EXECR below
  always_comb begin
    w_alu_op = 3'b000;
    case (funct3)
      3'b000:  w_alu_op = funct7b5 ? 3'b001 : 3'b000;
      3'b010:  w_alu_op = 3'b101;
      3'b110:  w_alu_op = 3'b011;
      3'b111:  w_alu_op = 3'b010;
      default: w_alu_op = 3'b000;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 3'b000;
    illegal    = 1'b0;
    // Reset gates everything so an abandoned access never leaves a strobe up
    if (!reset) begin
      case (r_state)
        c_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        c_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          if (op == c_OP_BRANCH)   ImmSrc = 3'b101;
          else if (op == c_OP_JAL) ImmSrc = 3'b110;
        end
        c_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == c_OP_STORE) ? 3'b001 : 3'b000;
        end
        c_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        c_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        c_MEMWRITE: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        c_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = w_alu_op;
        end
        c_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = (funct3 == 3'b000) ? 3'b000 : w_alu_op;
        end
        c_ALUWB:  RegWrite = 1'b1;
        c_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = 3'b001;
          PCWrite    = zero ^ funct3[0];
        end
        c_JAL: begin
          PCWrite = 1'b1;
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        c_LUI: begin
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b01;
          ImmSrc  = 3'b010;
        end
        c_TRAP:   illegal = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Table-driven per-cycle check of the multicycle control FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // strb = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite}
  typedef struct packed {
    logic [3:0] st;
    logic [5:0] strb;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
    logic       ill;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, rdy;
    outs_t      exp;
    string      name;
  } vec_t;

  vec_t  vecs[$];
  outs_t sb_q[$];
  int    checks = 0;
  int    fails  = 0;

  function automatic outs_t o(input logic [3:0] st, input logic [5:0] strb,
                              input logic [1:0] rs, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [2:0] alu,
                              input logic [2:0] imm, input logic ill);
    o = '{st, strb, rs, sa, sb, alu, imm, ill};
  endfunction

  function automatic outs_t sample();
    sample = {state, mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
              ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};
  endfunction

  task automatic add(input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy,
                     input outs_t e, input string nm);
    vec_t v;
    v.rst = rst; v.op = opc; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
    v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic compare(input outs_t got, input string nm);
    outs_t e;
    checks++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, got %h", nm, got);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL %s: got %h required %h", nm, got, e);
      end
    end
  endtask

  // One cycle: drive after the edge, push expectation, compare mid-cycle
  task automatic run_vec(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7;
    zero = v.z; mem_ready = v.rdy;
    sb_q.push_back(v.exp);
    @(negedge clk);
    compare(sample(), v.name);
  endtask

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         LU = 7'b0110111;

  outs_t ZERO, F_STALL, F_GO, ALUWB, TRAPO;

  initial begin
    vec_t v;
    ZERO    = '0;
    F_STALL = o(0, 6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0);
    F_GO    = o(0, 6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0);
    ALUWB   = o(8, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    TRAPO   = o(12, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1);

    add(1, LW, 3'b010, 0, 0, 0, ZERO,    "reset_all_zero");
    add(0, LW, 3'b010, 0, 0, 0, F_STALL, "fetch_stall_after_reset");
    add(0, LW, 3'b010, 0, 0, 0, F_STALL, "fetch_stall_no_irwrite");
    // lw, with one MEMREAD wait and mem_ready low where it must be ignored
    add(0, LW, 3'b010, 0, 0, 1, F_GO, "lw_fetch");
    add(0, LW, 3'b010, 0, 0, 0, o(1, 0, 0, 2'b01, 2'b01, 0, 3'b000, 0), "lw_decode");
    add(0, LW, 3'b010, 0, 0, 1, o(2, 0, 0, 2'b10, 2'b01, 0, 3'b000, 0), "lw_memadr");
    add(0, LW, 3'b010, 0, 0, 0, o(3, 6'b110000, 0, 0, 0, 0, 0, 0), "lw_memread_wait");
    add(0, LW, 3'b010, 0, 0, 1, o(3, 6'b110000, 0, 0, 0, 0, 0, 0), "lw_memread");
    add(0, LW, 3'b010, 0, 0, 0, o(4, 6'b000001, 2'b01, 0, 0, 0, 0, 0), "lw_memwb");
    // sw with three stall cycles
    add(0, SW, 3'b010, 0, 0, 1, F_GO, "sw_fetch");
    add(0, SW, 3'b010, 0, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 3'b000, 0), "sw_decode");
    add(0, SW, 3'b010, 0, 0, 1, o(2, 0, 0, 2'b10, 2'b01, 0, 3'b001, 0), "sw_memadr");
    for (int i = 0; i < 3; i++)
      add(0, SW, 3'b010, 0, 0, 0, o(5, 6'b111000, 0, 0, 0, 0, 0, 0), "sw_memwrite_wait");
    add(0, SW, 3'b010, 0, 0, 1, o(5, 6'b111000, 0, 0, 0, 0, 0, 0), "sw_memwrite_done");
    // beq taken, bne not taken
    add(0, BR, 3'b000, 0, 1, 1, F_GO, "beq_fetch");
    add(0, BR, 3'b000, 0, 1, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 3'b101, 0), "beq_decode");
    add(0, BR, 3'b000, 0, 1, 1, o(9, 6'b000010, 0, 2'b10, 2'b00, 3'b001, 0, 0), "beq_taken");
    add(0, BR, 3'b001, 0, 1, 1, F_GO, "bne_fetch");
    add(0, BR, 3'b001, 0, 1, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 3'b101, 0), "bne_decode");
    add(0, BR, 3'b001, 0, 1, 1, o(9, 6'b000000, 0, 2'b10, 2'b00, 3'b001, 0, 0), "bne_not_taken");
    // R-type sub and slt
    add(0, RT, 3'b000, 1, 0, 1, F_GO, "sub_fetch");
    add(0, RT, 3'b000, 1, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0), "sub_decode");
    add(0, RT, 3'b000, 1, 0, 1, o(6, 0, 0, 2'b10, 2'b00, 3'b001, 0, 0), "sub_execr");
    add(0, RT, 3'b000, 1, 0, 1, ALUWB, "sub_aluwb");
    add(0, RT, 3'b010, 0, 0, 1, F_GO, "slt_fetch");
    add(0, RT, 3'b010, 0, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0), "slt_decode");
    add(0, RT, 3'b010, 0, 0, 1, o(6, 0, 0, 2'b10, 2'b00, 3'b101, 0, 0), "slt_execr");
    add(0, RT, 3'b010, 0, 0, 1, ALUWB, "slt_aluwb");
    // addi with funct7b5 set stays add; ori
    add(0, IT, 3'b000, 1, 0, 1, F_GO, "addi_fetch");
    add(0, IT, 3'b000, 1, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0), "addi_decode");
    add(0, IT, 3'b000, 1, 0, 1, o(7, 0, 0, 2'b10, 2'b01, 3'b000, 0, 0), "addi_execi");
    add(0, IT, 3'b000, 1, 0, 1, ALUWB, "addi_aluwb");
    add(0, IT, 3'b110, 0, 0, 1, F_GO, "ori_fetch");
    add(0, IT, 3'b110, 0, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0), "ori_decode");
    add(0, IT, 3'b110, 0, 0, 1, o(7, 0, 0, 2'b10, 2'b01, 3'b011, 0, 0), "ori_execi");
    add(0, IT, 3'b110, 0, 0, 1, ALUWB, "ori_aluwb");
    // lui and jal
    add(0, LU, 3'b000, 0, 0, 1, F_GO, "lui_fetch");
    add(0, LU, 3'b000, 0, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0), "lui_decode");
    add(0, LU, 3'b000, 0, 0, 1, o(11, 0, 0, 2'b11, 2'b01, 0, 3'b010, 0), "lui_exec");
    add(0, LU, 3'b000, 0, 0, 1, ALUWB, "lui_aluwb");
    add(0, JL, 3'b000, 0, 0, 1, F_GO, "jal_fetch");
    add(0, JL, 3'b000, 0, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 3'b110, 0), "jal_decode");
    add(0, JL, 3'b000, 0, 0, 1, o(10, 6'b000010, 2'b00, 2'b01, 2'b10, 0, 0, 0), "jal_exec");
    add(0, JL, 3'b000, 0, 0, 1, ALUWB, "jal_aluwb");
    // illegal opcode: trap holds, reset clears
    add(0, 7'b0000000, 3'b000, 0, 0, 1, F_GO, "ill_fetch");
    add(0, 7'b0000000, 3'b000, 0, 0, 1, o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0), "ill_decode");
    for (int i = 0; i < 10; i++)
      add(0, 7'b0000000, 3'b000, 0, 0, 1, TRAPO, "ill_trap_hold");
    add(1, 7'b0000000, 3'b000, 0, 0, 1, ZERO, "trap_reset");
    add(0, LW, 3'b010, 0, 0, 0, F_STALL, "trap_release_fetch");

    foreach (vecs[i]) run_vec(vecs[i]);

    // lw with unsupported funct3 traps
    v.rst = 0; v.op = LW; v.f3 = 3'b000; v.f7 = 0; v.z = 0; v.rdy = 1;
    v.exp = F_GO; v.name = "lwf3_fetch"; run_vec(v);
    v.exp = o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0); v.name = "lwf3_decode"; run_vec(v);
    v.exp = TRAPO; v.name = "lwf3_trap"; run_vec(v);
    v.rst = 1; v.exp = ZERO; v.name = "lwf3_reset"; run_vec(v);

    // reset mid-store: MemWrite must drop before any clock edge
    v.rst = 0; v.op = SW; v.f3 = 3'b010; v.rdy = 1;
    v.exp = F_GO; v.name = "sr_fetch"; run_vec(v);
    v.exp = o(1, 0, 0, 2'b01, 2'b01, 0, 0, 0); v.name = "sr_decode"; run_vec(v);
    v.exp = o(2, 0, 0, 2'b10, 2'b01, 0, 3'b001, 0); v.name = "sr_memadr"; run_vec(v);
    v.rdy = 0; v.exp = o(5, 6'b111000, 0, 0, 0, 0, 0, 0); v.name = "sr_memwrite"; run_vec(v);
    #1 reset = 1'b1;
    #1;
    sb_q.push_back(ZERO);
    compare(sample(), "async_reset_mid_store");
    v.rst = 1; v.exp = ZERO; v.name = "sr_reset_held"; run_vec(v);
    v.rst = 0; v.exp = F_STALL; v.name = "sr_release"; run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
